// File: rtl/cacheline_burst_adapter.sv
// Cache line <-> burst memory adapter.
// Breaks one 256-bit line transfer into BEATS memory beats and rebuilds it. A writeback line
// is latched and sent one beat at a time; read beats are collected into one fill line.
// Optional build macro: CACHELINE_ADAPTER_POSTED_WB_EN. When it is defined, writebacks are
// acknowledged (line_resp_o) the cycle after they are accepted, before the burst starts.

module cacheline_burst_adapter #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OffW  = $clog2(LINE_W / 8);

  localparam logic [BeatW-1:0]  LastBeat = BeatW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'((64'd1 << OffW) - 64'd1);

`ifdef CACHELINE_ADAPTER_POSTED_WB_EN
  typedef enum logic [2:0] {StIdle, StRdBurst, StWrBurst, StDone, StWbAck} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;
`endif

  state_e                         state_q, state_d;
  logic [BeatW-1:0]               beat_q, beat_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [BEATS-1:0][BURST_W-1:0]  wdata_q, wdata_d;
  logic [BEATS-1:0][BURST_W-1:0]  fill_q, fill_d;
  logic [LINE_W-1:0]              rdata_q, rdata_d;
  logic                           mem_read_q, mem_read_d;
  logic                           mem_write_q, mem_write_d;
  logic                           line_resp;

  // Next-state: request acceptance, beat sequencing and line assembly.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fill_d      = fill_q;
    rdata_d     = rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    line_resp   = 1'b0;

    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        // Write has priority over read when both are requested.
        if (line_write_i) begin
          addr_d  = line_addr_i & ~OffMask;
          wdata_d = line_wdata_i;
`ifdef CACHELINE_ADAPTER_POSTED_WB_EN
          state_d = StWbAck;
`else
          state_d     = StWrBurst;
          mem_write_d = 1'b1;
`endif
        end else if (line_read_i) begin
          addr_d     = line_addr_i & ~OffMask;
          state_d    = StRdBurst;
          mem_read_d = 1'b1;
        end
      end

      StRdBurst: begin
        if (mem_resp_i) begin
          fill_d[beat_q] = mem_rdata_i;
          if (beat_q == LastBeat) begin
            // Publish the whole line at once so line_rdata_o never shows a partial fill.
            rdata_d    = fill_d;
            beat_d     = '0;
            mem_read_d = 1'b0;
            state_d    = StDone;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

      StWrBurst: begin
        if (mem_resp_i) begin
          if (beat_q == LastBeat) begin
            beat_d      = '0;
            mem_write_d = 1'b0;
`ifdef CACHELINE_ADAPTER_POSTED_WB_EN
            // Already acknowledged in StWbAck; drain ends silently.
            state_d = StIdle;
`else
            state_d = StDone;
`endif
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

`ifdef CACHELINE_ADAPTER_POSTED_WB_EN
      StWbAck: begin
        line_resp   = 1'b1;
        mem_write_d = 1'b1;
        state_d     = StWrBurst;
      end
`endif

      StDone: begin
        line_resp = 1'b1;
        beat_d    = '0;
        state_d   = StIdle;
      end

      default: begin
        beat_d      = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any partial burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fill_q      <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fill_q      <= fill_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign line_rdata_o = rdata_q;
  assign line_resp_o  = line_resp;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q[beat_q];

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter (default build, non-posted writes).
// A transaction-level model in the bench supplies the memory side and predicts every output.

module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_vec = 0;
  int n_err = 0;

  // Most recently completed fill line; reset clears it.
  logic [255:0] exp_rdata;

  cacheline_burst_adapter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .line_read_i  (line_read),
    .line_write_i (line_write),
    .line_addr_i  (line_addr),
    .line_wdata_i (line_wdata),
    .line_rdata_o (line_rdata),
    .line_resp_o  (line_resp),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_resp_i   (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete line transaction. Memory beats come after gaps drawn from [gap_lo, gap_hi].
  // Call from #1 after an edge with the DUT idle; returns in the same phase with the DUT idle.
  task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int gap_lo, input int gap_hi);
    logic [31:0] exp_addr;
    int          beat;
    int          gap;
    bit          expect_resp;
    bit          done;
    exp_addr    = {addr[31:5], 5'b0};
    line_addr   = addr;
    line_wdata  = wline;
    line_write  = is_wr;
    line_read   = !is_wr || both;
    // Junk handshake while still idle must be ignored.
    mem_resp    = 1'($urandom_range(1, 0));
    mem_rdata   = {$urandom, $urandom};
    beat        = 0;
    gap         = $urandom_range(gap_hi, gap_lo);
    expect_resp = 1'b0;
    done        = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      tick();
      if (expect_resp) begin
        check_eq("line_resp", 256'(line_resp), 256'(1));
        check_eq("req_drop", 256'({mem_read, mem_write}), 256'(0));
        check_eq("line_rdata", line_rdata, is_wr ? exp_rdata : rline);
        if (!is_wr) exp_rdata = rline;
        line_read  = 1'b0;
        line_write = 1'b0;
        // Stray handshake during the response cycle must be ignored.
        mem_resp   = 1'($urandom_range(1, 0));
        done       = 1'b1;
      end else begin
        check_eq("early_resp", 256'(line_resp), 256'(0));
        check_eq("mem_read", 256'(mem_read), 256'(!is_wr));
        check_eq("mem_write", 256'(mem_write), 256'(is_wr));
        check_eq("mem_addr", 256'(mem_addr), 256'(exp_addr));
        check_eq("rdata_hold", line_rdata, exp_rdata);
        if (is_wr) check_eq("mem_wdata", 256'(mem_wdata), 256'(wline[beat*64 +: 64]));
        // Input changes after acceptance must not leak into the transaction.
        line_addr  = $urandom;
        line_wdata = rand_line();
        if (gap > 0) begin
          gap--;
          mem_resp  = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end else begin
          mem_resp  = 1'b1;
          mem_rdata = rline[beat*64 +: 64];
          beat++;
          gap = $urandom_range(gap_hi, gap_lo);
          if (beat == 4) expect_resp = 1'b1;
        end
      end
    end
    if (!done) check_eq("txn_timeout", 256'(0), 256'(1));
    tick();
    check_eq("idle_resp", 256'(line_resp), 256'(0));
    check_eq("idle_mem", 256'({mem_read, mem_write}), 256'(0));
    mem_resp = 1'b0;
  endtask

  initial begin
    logic [255:0] l0, l1;
    rst        = 1'b1;
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = '0;
    line_wdata = '0;
    mem_rdata  = '0;
    mem_resp   = 1'b0;
    exp_rdata  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_mem_read", 256'(mem_read), 256'(0));
    check_eq("rst_mem_write", 256'(mem_write), 256'(0));
    check_eq("rst_line_resp", 256'(line_resp), 256'(0));
    check_eq("rst_mem_addr", 256'(mem_addr), 256'(0));
    check_eq("rst_line_rdata", line_rdata, 256'(0));

    // Spurious handshakes while idle: nothing may start
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1;
      tick();
      check_eq("spur_idle", 256'({line_resp, mem_read, mem_write}), 256'(0));
    end
    mem_resp = 1'b0;

    // Directed read fill, back-to-back beats
    l0 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn(1'b0, 1'b0, 32'h0000_1234, '0, l0, 0, 0);
    check_eq("dir_fill", line_rdata, l0);

    // Directed write, two idle cycles before every beat
    l1 = rand_line();
    run_txn(1'b1, 1'b0, 32'h0000_ABCD, l1, rand_line(), 2, 2);

    // Read and write together: write first, then the read
    l0 = rand_line();
    run_txn(1'b1, 1'b1, 32'h0000_4000, rand_line(), rand_line(), 0, 1);
    run_txn(1'b0, 1'b0, 32'h0000_4000, '0, l0, 0, 1);

    // Reset after two read beats: burst abandoned, no response, fill line cleared
    line_read = 1'b1;
    line_addr = 32'h0000_8040;
    tick();
    check_eq("rr_mem_read", 256'(mem_read), 256'(1));
    mem_resp  = 1'b1;
    mem_rdata = 64'hDEAD_0000_0000_0000;
    tick();
    mem_rdata = 64'hDEAD_0000_0000_0001;
    tick();
    mem_resp  = 1'b0;
    rst       = 1'b1;
    line_read = 1'b0;
    tick();
    rst       = 1'b0;
    exp_rdata = '0;
    check_eq("rr_mem_read_low", 256'({mem_read, mem_write}), 256'(0));
    check_eq("rr_no_resp", 256'(line_resp), 256'(0));
    check_eq("rr_rdata_clr", line_rdata, 256'(0));
    tick();
    check_eq("rr_no_resp2", 256'(line_resp), 256'(0));
    l0 = rand_line();
    run_txn(1'b0, 1'b0, 32'h0000_8040, '0, l0, 0, 2);
    check_eq("rr_beat0", 256'(line_rdata[63:0]), 256'(l0[63:0]));

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      bit wr;
      wr = 1'($urandom_range(1, 0));
      run_txn(wr, wr && ($urandom_range(3, 0) == 0), $urandom, rand_line(), rand_line(), 0, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
